// File: rtl/barrel_pkg.sv
// Shared definitions for the ones-fill barrel shifter family:
// datapath sizes, the fill value and the iterative-unit state encoding.
package barrel_pkg;

    localparam int   WIDTH = 16;
    localparam int   CW    = 4;
    localparam logic FILL  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/norm_step.sv
// Single combinational normalization step: tests the active edge bit for
// fill and produces the word moved one place away from that edge.
module norm_step #(
    parameter int WIDTH = barrel_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] word,
    input  logic             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] next_word,
    output logic             edge_fill
);

    logic edge_bit;

    assign edge_bit  = dir ? word[0] : word[WIDTH-1];
    assign edge_fill = (edge_bit == fill);

    // The vacated position always receives 0, whatever the fill value.
    assign next_word = dir ? {1'b0, word[WIDTH-1:1]} : {word[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/barrel_normalizer.sv
// Iterative inverse of the ones-fill barrel shifter: strips fill bits from
// one edge of a word at one bit per clock, behind valid/ready handshakes.
module barrel_normalizer #(
    parameter int   WIDTH = barrel_pkg::WIDTH,
    parameter int   CW    = barrel_pkg::CW,
    parameter logic FILL  = barrel_pkg::FILL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_count,
    output logic             out_all_fill
);

    import barrel_pkg::*;

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] work;
    logic             dir;
    logic [CW-1:0]    count;
    logic             all_fill;
    logic [WIDTH-1:0] next_word;
    logic             edge_fill;

    norm_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .word      (work),
        .dir       (dir),
        .fill      (FILL),
        .next_word (next_word),
        .edge_fill (edge_fill)
    );

    // Saturating at WIDTH-1 leaves one fill bit behind on an all-fill word,
    // which keeps the count within CW bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            work     <= '0;
            dir      <= 1'b0;
            count    <= '0;
            all_fill <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= in_data;
                        dir      <= in_dir;
                        count    <= '0;
                        all_fill <= (in_data == {WIDTH{FILL}});
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (edge_fill && (count != CNT_MAX)) begin
                        work  <= next_word;
                        count <= count + 1'b1;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == DONE);
    assign out_data     = work;
    assign out_count    = count;
    assign out_all_fill = all_fill;

endmodule

// File: tb/tb_barrel_normalizer.sv
// Directed, table-driven bench for barrel_normalizer plus hand-written
// sequences for backpressure, back-to-back throughput and mid-shift reset.
module tb_barrel_normalizer;

    localparam int WIDTH = 16;
    localparam int CW    = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dir;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_count;
    logic             out_all_fill;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             dir;
        logic [WIDTH-1:0] exp_data;
        logic [CW-1:0]    exp_count;
        logic             exp_all;
        int               exp_lat;
    } vec_t;

    vec_t vecs[10];

    barrel_normalizer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_dir       (in_dir),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_count    (out_count),
        .out_all_fill (out_all_fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offers one word, lets it be accepted, and returns the number of edges
    // from the accepting edge until out_valid is seen (0 on timeout).
    task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic dir,
                                 output int lat);
        int waited;
        waited = 0;
        while (!in_ready && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("in_ready before offer", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        in_dir   = dir;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        in_dir   = ~dir;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (out_valid) begin
                lat = i - 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!out_valid) begin
            lat = 0;
            checkOutput("out_valid timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic runVector(input vec_t v);
        int lat;
        applyStimulus(v.data, v.dir, lat);
        checkOutput("out_data", {16'd0, out_data}, {16'd0, v.exp_data});
        checkOutput("out_count", {28'd0, out_count}, {28'd0, v.exp_count});
        checkOutput("out_all_fill", {31'd0, out_all_fill}, {31'd0, v.exp_all});
        checkOutput("latency", lat, v.exp_lat);
        checkOutput("in_ready in DONE", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        checkOutput("out_valid after take", {31'd0, out_valid}, 32'd0);
        checkOutput("in_ready after take", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{16'hF0A5, 1'b0, 16'h0A50, 4'd4,  1'b0, 5};
        vecs[1] = '{16'h12FF, 1'b1, 16'h0012, 4'd8,  1'b0, 9};
        vecs[2] = '{16'hFFFF, 1'b0, 16'h8000, 4'd15, 1'b1, 16};
        vecs[3] = '{16'hFFFF, 1'b1, 16'h0001, 4'd15, 1'b1, 16};
        vecs[4] = '{16'h7FFF, 1'b0, 16'h7FFF, 4'd0,  1'b0, 1};
        vecs[5] = '{16'h0001, 1'b1, 16'h0000, 4'd1,  1'b0, 2};
        vecs[6] = '{16'h8000, 1'b0, 16'h0000, 4'd1,  1'b0, 2};
        vecs[7] = '{16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0, 1};
        vecs[8] = '{16'hFFFE, 1'b1, 16'hFFFE, 4'd0,  1'b0, 1};
        vecs[9] = '{16'hFFFE, 1'b0, 16'h0000, 4'd15, 1'b0, 16};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dir    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset out_data", {16'd0, out_data}, 32'd0);
        checkOutput("reset out_count", {28'd0, out_count}, 32'd0);
        checkOutput("reset out_all_fill", {31'd0, out_all_fill}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            runVector(vecs[i]);
        end

        // Back-to-back zero-count words: accept, DONE, IDLE, accept again.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h7FFF, 1'b0, lat);
            checkOutput("b2b latency", lat, 1);
            checkOutput("b2b out_data", {16'd0, out_data}, 32'h7FFF);
            @(posedge clk); #1;
            checkOutput("b2b in_ready", {31'd0, in_ready}, 32'd1);
        end

        // Backpressure: hold DONE, offer a new word that must be ignored.
        out_ready = 1'b0;
        applyStimulus(16'hF0A5, 1'b0, lat);
        checkOutput("bp latency", lat, 5);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        in_dir   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput("bp out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("bp out_data", {16'd0, out_data}, 32'h0A50);
            checkOutput("bp out_count", {28'd0, out_count}, 32'd4);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp released in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("bp released out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("bp held out_data", {16'd0, out_data}, 32'h0A50);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("bp new word busy", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        checkOutput("bp new out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp new out_data", {16'd0, out_data}, 32'h1234);
        checkOutput("bp new out_count", {28'd0, out_count}, 32'd0);
        @(posedge clk); #1;

        // Reset mid-SHIFT after three strips of 0xFF00.
        in_valid = 1'b1;
        in_data  = 16'hFF00;
        in_dir   = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pre-reset out_count", {28'd0, out_count}, 32'd3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("mid reset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("mid reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid reset out_data", {16'd0, out_data}, 32'd0);
        checkOutput("mid reset out_count", {28'd0, out_count}, 32'd0);
        runVector('{16'hC3C3, 1'b0, 16'h0F0C, 4'd2, 1'b0, 3});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
